// File: rtl/ita_package.sv
// Shared types and constants for the ITA step sequencer.
// The sequencer state, outstanding-tile counter type and default
// outstanding limit live here next to the step/layer/control types.
package ita_package;

  // Bits needed to index n distinct values (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int H                 = 4;
  localparam int N_REQUANT_CONSTS  = 8;
  localparam int TileW             = 8;
  localparam int SeqMaxOutstanding = 2;

  typedef logic [TileW-1:0]             tile_t;
  typedef logic [idx_width(H+1)-1:0]    n_heads_t;
  // Sized for the largest legal outstanding limit (15).
  typedef logic [idx_width(15+1)-1:0]   outstanding_t;

  typedef enum logic [3:0] {
    Idle   = 4'd0,
    Q      = 4'd1,
    K      = 4'd2,
    V      = 4'd3,
    QK     = 4'd4,
    AV     = 4'd5,
    OW     = 4'd6,
    F1     = 4'd7,
    F2     = 4'd8,
    MatMul = 4'd9
  } step_e;

  typedef enum logic [1:0] {
    Attention   = 2'd0,
    Feedforward = 2'd1,
    Linear      = 2'd2
  } layer_e;

  typedef struct packed {
    logic   start;
    layer_e layer;
    tile_t  tile_s;
    tile_t  tile_e;
    tile_t  tile_p;
    tile_t  tile_f;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ita_tile_counter.sv
// Row-major tile position counter: the column steps first and wraps
// to 0 after cols-1, carrying into the row. last_o flags the final
// tile of the grid.
module ita_tile_counter
  import ita_package::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  tile_t rows_i,
  input  tile_t cols_i,
  input  logic  advance_i,
  input  logic  clear_i,
  output tile_t row_o,
  output tile_t col_o,
  output logic  last_o
);

  localparam tile_t One = tile_t'(1);

  tile_t row_q, row_d;
  tile_t col_q, col_d;

  // Next position: clear wins, otherwise step the column and carry into the row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == cols_i - One) begin
        col_d = '0;
        row_d = row_q + One;
      end else begin
        col_d = col_q + One;
      end
    end
  end

  // Position register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == rows_i - One) && (col_q == cols_i - One);

endmodule

// File: rtl/ita_step_sequencer.sv
// Issues compute tiles step by step for one ITA layer, bounding the
// number of tiles in flight and waiting for all of them to complete
// before starting the next step.
// Optional feature macro: ITA_SEQ_HEAD_LOOP_EN repeats Q..AV per head,
// then runs OW once; without it a single pass is made with head 0.
module ita_step_sequencer
  import ita_package::*;
#(
  parameter int unsigned MaxOutstanding = SeqMaxOutstanding,
  parameter int unsigned MaxHeads       = H
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  ctrl_t                                 ctrl_i,
  input  n_heads_t                              n_heads_i,
  output logic                                  tile_valid_o,
  input  logic                                  tile_ready_i,
  output step_e                                 step_o,
  output tile_t                                 tile_row_o,
  output tile_t                                 tile_col_o,
  output n_heads_t                              head_o,
  output logic [idx_width(N_REQUANT_CONSTS)-1:0] req_idx_o,
  input  logic                                  tile_done_i,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int           ReqW      = idx_width(N_REQUANT_CONSTS);
  localparam outstanding_t OutOne    = outstanding_t'(1);
  localparam outstanding_t MaxOuts   = outstanding_t'(MaxOutstanding);
  localparam n_heads_t     HeadOne   = n_heads_t'(1);
  localparam n_heads_t     MaxHeadsT = n_heads_t'(MaxHeads);

  seq_state_e   state_q, state_d;
  layer_e       layer_q, layer_d;
  tile_t        ts_q, ts_d, te_q, te_d, tp_q, tp_d, tf_q, tf_d;
  n_heads_t     nh_q, nh_d;
  step_e        step_q, step_d;
  n_heads_t     head_q, head_d;
  outstanding_t outs_q, outs_d;

  tile_t    rows, cols, row, col;
  logic     last, step_empty, at_origin, room, tile_valid, handover, done_dec;
  logic     cnt_adv, cnt_clr, seq_end;
  step_e    nxt_step, first_step;
  n_heads_t nxt_head;
  logic [3:0] step_m1;

`ifndef ITA_SEQ_HEAD_LOOP_EN
  logic unused_n_heads;
  assign unused_n_heads = ^{n_heads_i, MaxHeadsT};
`endif

  // Grid size of the current step.
  always_comb begin
    rows = ts_q;
    cols = tp_q;
    unique case (step_q)
      QK:      cols = ts_q;
      OW, F2:  cols = te_q;
      F1:      cols = tf_q;
      default: cols = tp_q;
    endcase
  end

  // Step that follows the current one, including the per-head loop.
  always_comb begin
    nxt_step = Idle;
    nxt_head = '0;
    seq_end  = 1'b0;
    unique case (step_q)
      Q:  nxt_step = K;
      K:  nxt_step = V;
      V:  nxt_step = QK;
      QK: nxt_step = AV;
      AV: begin
        if ((head_q + HeadOne) < nh_q) begin
          nxt_step = Q;
          nxt_head = head_q + HeadOne;
        end else begin
          nxt_step = OW;
        end
      end
      F1:      nxt_step = F2;
      default: seq_end  = 1'b1;
    endcase
  end

  // First step of the requested layer.
  always_comb begin
    unique case (ctrl_i.layer)
      Attention:   first_step = Q;
      Feedforward: first_step = F1;
      default:     first_step = MatMul;
    endcase
  end

  assign step_empty = (rows == '0) || (cols == '0);
  assign at_origin  = (row == '0) && (col == '0);
  // A completing tile in this cycle frees a slot immediately.
  assign room       = (outs_q < MaxOuts) || tile_done_i;
  // The first tile of a step waits for every earlier tile to complete.
  assign tile_valid = (state_q == ISSUE) && !step_empty && room &&
                      (!at_origin || (outs_q == '0));
  assign handover   = tile_valid && tile_ready_i;
  assign done_dec   = tile_done_i && (outs_q != '0);

  // Outstanding-tile bookkeeping; stray completions at zero are dropped.
  always_comb begin
    outs_d = outs_q;
    if (handover && !done_dec)      outs_d = outs_q + OutOne;
    else if (!handover && done_dec) outs_d = outs_q - OutOne;
  end

  // Sequencer next state and per-run latches.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    ts_d    = ts_q;
    te_d    = te_q;
    tp_d    = tp_q;
    tf_d    = tf_q;
    nh_d    = nh_q;
    step_d  = step_q;
    head_d  = head_q;
    cnt_adv = 1'b0;
    cnt_clr = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (ctrl_i.start) begin
          state_d = ISSUE;
          layer_d = ctrl_i.layer;
          ts_d    = ctrl_i.tile_s;
          te_d    = ctrl_i.tile_e;
          tp_d    = ctrl_i.tile_p;
          tf_d    = ctrl_i.tile_f;
          step_d  = first_step;
          head_d  = '0;
          cnt_clr = 1'b1;
`ifdef ITA_SEQ_HEAD_LOOP_EN
          if (n_heads_i == '0)           nh_d = HeadOne;
          else if (n_heads_i > MaxHeadsT) nh_d = MaxHeadsT;
          else                            nh_d = n_heads_i;
`else
          nh_d = HeadOne;
`endif
        end
      end
      ISSUE: begin
        if (step_empty || (handover && last)) begin
          cnt_clr = 1'b1;
          if (seq_end) begin
            state_d = DRAIN;
            step_d  = Idle;
            head_d  = '0;
          end else begin
            step_d  = nxt_step;
            head_d  = nxt_head;
          end
        end else if (handover) begin
          cnt_adv = 1'b1;
        end
      end
      DRAIN: begin
        if (outs_q == '0) state_d = DONE;
      end
      default: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      layer_q <= Attention;
      ts_q    <= '0;
      te_q    <= '0;
      tp_q    <= '0;
      tf_q    <= '0;
      nh_q    <= '0;
      step_q  <= Idle;
      head_q  <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      ts_q    <= ts_d;
      te_q    <= te_d;
      tp_q    <= tp_d;
      tf_q    <= tf_d;
      nh_q    <= nh_d;
      step_q  <= step_d;
      head_q  <= head_d;
      outs_q  <= outs_d;
    end
  end

  ita_tile_counter u_tile_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rows_i    (rows),
    .cols_i    (cols),
    .advance_i (cnt_adv),
    .clear_i   (cnt_clr),
    .row_o     (row),
    .col_o     (col),
    .last_o    (last)
  );

  // Requant index: one slot per step from Q to F2, MatMul and Idle share slot 0.
  always_comb begin
    step_m1   = step_q - 4'd1;
    req_idx_o = step_m1[ReqW-1:0];
    if ((step_q == MatMul) || (step_q == Idle)) req_idx_o = '0;
  end

  assign tile_valid_o = tile_valid;
  assign step_o       = step_q;
  assign tile_row_o   = row;
  assign tile_col_o   = col;
  assign head_o       = head_q;

endmodule

// File: tb/tb_ita_step_sequencer.sv
// Directed bench for ita_step_sequencer: expected tiles are queued when a
// run is started and matched against each handover; completions are
// returned a fixed number of cycles after handover.
module tb_ita_step_sequencer;
  import ita_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst_n;
  ctrl_t    ctrl;
  n_heads_t n_heads;
  logic     tile_ready;
  logic     tile_done;
  logic     tile_valid_o;
  step_e    step_o;
  tile_t    tile_row_o, tile_col_o;
  n_heads_t head_o;
  logic [idx_width(N_REQUANT_CONSTS)-1:0] req_idx_o;
  logic     busy_o, done_o;

  ita_step_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ctrl_i       (ctrl),
    .n_heads_i    (n_heads),
    .tile_valid_o (tile_valid_o),
    .tile_ready_i (tile_ready),
    .step_o       (step_o),
    .tile_row_o   (tile_row_o),
    .tile_col_o   (tile_col_o),
    .head_o       (head_o),
    .req_idx_o    (req_idx_o),
    .tile_done_i  (tile_done),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    step_e step;
    int    row;
    int    col;
    int    head;
    int    req;
  } exp_t;

  exp_t sb[$];
  int   due_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   handovers = 0;
  int   done_pulses = 0;
  int   tb_outs = 0;
  bit   hold_done = 1'b0;
  int   done_lat = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int req_of(input step_e s);
    case (s)
      Q: return 0;   K: return 1;   V: return 2;  QK: return 3;
      AV: return 4;  OW: return 5;  F1: return 6; F2: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic push_step(input step_e st, input int head, input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        sb.push_back('{step: st, row: r, col: c, head: head, req: req_of(st)});
  endtask

  task automatic push_run(input layer_e l, input int ts, input int te, input int tp,
                          input int tf, input int nh);
    int nhe;
    nhe = 1;
`ifdef ITA_SEQ_HEAD_LOOP_EN
    nhe = (nh == 0) ? 1 : ((nh > H) ? H : nh);
`endif
    $display("run layer=%0d s=%0d e=%0d p=%0d f=%0d nheads=%0d", l, ts, te, tp, tf, nh);
    case (l)
      Attention: begin
        for (int h = 0; h < nhe; h++) begin
          push_step(Q, h, ts, tp);
          push_step(K, h, ts, tp);
          push_step(V, h, ts, tp);
          push_step(QK, h, ts, ts);
          push_step(AV, h, ts, tp);
        end
        push_step(OW, 0, ts, te);
      end
      Feedforward: begin
        push_step(F1, 0, ts, tf);
        push_step(F2, 0, ts, te);
      end
      default: push_step(MatMul, 0, ts, tp);
    endcase
  endtask

  // Handover monitor: match each tile against the scoreboard.
  initial begin
    exp_t e;
    bit   ho;
    bit   dn;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tb_outs = 0;
      end else begin
        if (done_o) done_pulses++;
        ho = tile_valid_o && tile_ready;
        dn = tile_done && (tb_outs > 0);
        if (ho) begin
          handovers++;
          check("sb_nonempty", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("tile step=%0d row=%0d col=%0d head=%0d req=%0d",
                     step_o, tile_row_o, tile_col_o, head_o, req_idx_o);
            check("step", int'(step_o), int'(e.step));
            check("row", int'(tile_row_o), e.row);
            check("col", int'(tile_col_o), e.col);
            check("head", int'(head_o), e.head);
            check("req_idx", int'(req_idx_o), e.req);
            if (e.row == 0 && e.col == 0) check("step_dep_outstanding", tb_outs, 0);
          end
          check("outstanding_room", int'(tb_outs < SeqMaxOutstanding || tile_done), 1);
          due_q.push_back(cyc + done_lat);
        end
        if (ho && !dn)      tb_outs++;
        else if (!ho && dn) tb_outs--;
      end
    end
  end

  // Completion returner: one tile_done pulse per cycle once due.
  initial begin
    tile_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tile_done = 1'b0;
      if (!rst_n) begin
        due_q.delete();
      end else if (!hold_done && due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        tile_done = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input layer_e l, input int ts, input int te, input int tp,
                          input int tf, input int nh);
    ctrl.layer  = l;
    ctrl.tile_s = tile_t'(ts);
    ctrl.tile_e = tile_t'(te);
    ctrl.tile_p = tile_t'(tp);
    ctrl.tile_f = tile_t'(tf);
    n_heads     = n_heads_t'(nh);
    ctrl.start  = 1'b1;
    tick();
    ctrl.start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
    tick();
  endtask

  task automatic wait_handovers(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && handovers < target) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(handovers >= target), 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(tile_valid_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_step"}, int'(step_o), 0);
    check({tag, "_row"}, int'(tile_row_o), 0);
    check({tag, "_col"}, int'(tile_col_o), 0);
    check({tag, "_head"}, int'(head_o), 0);
    check({tag, "_req"}, int'(req_idx_o), 0);
  endtask

  initial begin
    int base_h;
    int base_d;
    int n;
    rst_n      = 1'b0;
    ctrl       = '0;
    n_heads    = '0;
    tile_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Linear 2x3 MatMul grid.
    base_h = handovers; base_d = done_pulses;
    push_run(Linear, 2, 0, 3, 0, 1);
    do_start(Linear, 2, 0, 3, 0, 1);
    wait_done("t1_done", 100);
    repeat (3) tick();
    check("t1_tiles", handovers - base_h, 6);
    check("t1_sb_empty", sb.size(), 0);
    check("t1_done_pulses", done_pulses - base_d, 1);
    check("t1_busy_after", int'(busy_o), 0);

    // Feedforward with completions withheld: stall at the limit.
    base_h = handovers;
    hold_done = 1'b1;
    push_run(Feedforward, 1, 1, 0, 2, 1);
    do_start(Feedforward, 1, 1, 0, 2, 1);
    repeat (10) tick();
    @(negedge clk);
    check("t2_stall_tiles", handovers - base_h, 2);
    check("t2_stall_valid", int'(tile_valid_o), 0);
    tick();
    hold_done = 1'b0;
    wait_done("t2_done", 100);
    check("t2_tiles", handovers - base_h, 3);
    check("t2_sb_empty", sb.size(), 0);

    // Attention all-ones, with an ignored second start.
    base_h = handovers; base_d = done_pulses;
    push_run(Attention, 1, 1, 1, 1, 1);
    do_start(Attention, 1, 1, 1, 1, 1);
    repeat (2) tick();
    @(negedge clk);
    check("t3_busy", int'(busy_o), 1);
    tick();
    do_start(Linear, 2, 2, 2, 2, 1);
    wait_done("t3_done", 200);
    repeat (4) tick();
    check("t3_tiles", handovers - base_h, 6);
    check("t3_sb_empty", sb.size(), 0);
    check("t3_done_pulses", done_pulses - base_d, 1);
    check("t3_busy_after", int'(busy_o), 0);

    // Empty Linear grid: no tiles, quick done.
    base_h = handovers;
    push_run(Linear, 2, 0, 0, 0, 1);
    do_start(Linear, 2, 0, 0, 0, 1);
    wait_done("t4_done_within_4", 4);
    check("t4_tiles", handovers - base_h, 0);

    // Back-pressure mid-step: outputs held at the pending tile.
    base_h = handovers;
    push_run(Linear, 1, 0, 6, 0, 1);
    do_start(Linear, 1, 0, 6, 0, 1);
    wait_handovers("t5_progress", base_h + 2, 30);
    tick();
    tile_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tile_valid_o && n < 10);
    check("t5_valid_at_hold", int'(tile_valid_o), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_sb_pending", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        check("t5_hold_valid", int'(tile_valid_o), 1);
        check("t5_hold_step", int'(step_o), int'(sb[0].step));
        check("t5_hold_row", int'(tile_row_o), sb[0].row);
        check("t5_hold_col", int'(tile_col_o), sb[0].col);
      end
    end
    tick();
    tile_ready = 1'b1;
    wait_done("t5_done", 100);
    check("t5_tiles", handovers - base_h, 6);
    check("t5_sb_empty", sb.size(), 0);

    // Reset mid-step abandons the run.
    base_h = handovers; base_d = done_pulses;
    push_run(Linear, 2, 0, 2, 0, 1);
    do_start(Linear, 2, 0, 2, 0, 1);
    wait_handovers("t6_progress", base_h + 1, 20);
    tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    @(negedge clk);
    check_idle_outputs("midreset");
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("t6_no_done", done_pulses - base_d, 0);

`ifdef ITA_SEQ_HEAD_LOOP_EN
    // Two heads: Q..AV per head, then OW on head 0.
    base_h = handovers;
    push_run(Attention, 1, 1, 1, 1, 2);
    do_start(Attention, 1, 1, 1, 1, 2);
    wait_done("t7_done", 300);
    check("t7_tiles", handovers - base_h, 11);
    check("t7_sb_empty", sb.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
